// File: rtl/ctrl_desp.sv
// ---------------------------------------------------------------------------
// ctrl_desp -- controller for an external 4-bit universal shift register that
// transmits one word serially and captures the word received on SER_IN.
//
// A transfer runs IDLE -> LOAD -> SHIFT (4 cycles) -> [PAR] -> CAPT -> IDLE.
// LOAD parallel-loads the register, SHIFT moves it four places (the register
// drives S_OUT while this block feeds S_IN from SER_IN), and CAPT copies the
// register contents into RX_WORD. DONE pulses in the IDLE cycle that follows.
//
// Optional feature: define CTRL_DESP_PARITY_EN to add a one-cycle PAR state in
// which SER_IN is sampled as an even-parity bit; PAR_ERR then reports the
// parity check of the captured word. Without the macro PAR_ERR is tied to 0.
//
// Ports
//   CLK       in   clock, all state changes on the rising edge
//   RST       in   asynchronous active-high reset
//   START     in   transfer request, only looked at in IDLE
//   DIN[3:0]  in   word to transmit, latched when START is accepted
//   DIR_CFG   in   shift direction latched at START (0 MSB first, 1 LSB first)
//   SER_IN    in   serial receive line
//   Q_IN[3:0] in   shift register parallel contents
//   ENB       out  shift register mode-load enable (always 1)
//   DIR       out  shift register direction
//   MODO[1:0] out  shift register mode (00 shift, 10 load, 11 hold)
//   D[3:0]    out  shift register parallel data (only non-zero in LOAD)
//   S_IN      out  shift register serial input (SER_IN during SHIFT)
//   BUSY      out  high whenever not IDLE
//   TX_VALID  out  S_OUT carries a valid transmitted bit this cycle
//   RX_WORD   out  last received word
//   DONE      out  one-cycle completion pulse
//   PAR_ERR   out  parity error of the last transfer, valid with DONE
// ---------------------------------------------------------------------------
module ctrl_desp (
   input  logic       CLK,
   input  logic       RST,
   input  logic       START,
   input  logic [3:0] DIN,
   input  logic       DIR_CFG,
   input  logic       SER_IN,
   input  logic [3:0] Q_IN,
   output logic       ENB,
   output logic       DIR,
   output logic [1:0] MODO,
   output logic [3:0] D,
   output logic       S_IN,
   output logic       BUSY,
   output logic       TX_VALID,
   output logic [3:0] RX_WORD,
   output logic       DONE,
   output logic       PAR_ERR
);

`ifdef CTRL_DESP_PARITY_EN
   typedef enum logic [2:0] {IDLE, LOAD, SHIFT, PAR, CAPT} state_t;
`else
   typedef enum logic [2:0] {IDLE, LOAD, SHIFT, CAPT} state_t;
`endif

   localparam logic [1:0] MODE_SHIFT = 2'b00;
   localparam logic [1:0] MODE_LOAD  = 2'b10;
   localparam logic [1:0] MODE_HOLD  = 2'b11;

   state_t     state_reg;
   logic [1:0] cnt_reg;
`ifdef CTRL_DESP_PARITY_EN
   logic       par_bit_reg;
`endif

   // The register is always enabled; MODO alone decides what it does.
   assign ENB  = 1'b1;
   // Serial receive path is a straight feed-through, gated to SHIFT so the
   // register sees a quiet 0 whenever it is not shifting.
   assign S_IN = (state_reg == SHIFT) ? SER_IN : 1'b0;

`ifndef CTRL_DESP_PARITY_EN
   assign PAR_ERR = 1'b0;
`endif

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_reg   <= IDLE;
         cnt_reg     <= 2'd0;
         MODO        <= MODE_HOLD;
         DIR         <= 1'b0;
         D           <= 4'd0;
         BUSY        <= 1'b0;
         TX_VALID    <= 1'b0;
         RX_WORD     <= 4'd0;
         DONE        <= 1'b0;
`ifdef CTRL_DESP_PARITY_EN
         par_bit_reg <= 1'b0;
         PAR_ERR     <= 1'b0;
`endif
      end else begin
         DONE <= 1'b0;
         case (state_reg)
            IDLE: begin
               TX_VALID <= 1'b0;
               if (START) begin
                  // DIN goes straight into D and DIR_CFG into DIR: these
                  // registers are the latched copies for the whole transfer.
                  state_reg <= LOAD;
                  MODO      <= MODE_LOAD;
                  D         <= DIN;
                  DIR       <= DIR_CFG;
                  BUSY      <= 1'b1;
               end
            end
            LOAD: begin
               state_reg <= SHIFT;
               cnt_reg   <= 2'd0;
               MODO      <= MODE_SHIFT;
               D         <= 4'd0;
            end
            SHIFT: begin
               cnt_reg  <= cnt_reg + 2'd1;
               // S_OUT is registered in the shift register, so the bit moved
               // out by each shift appears one cycle later: cnt 1..3 and the
               // cycle after SHIFT carry the four transmitted bits.
               TX_VALID <= 1'b1;
               if (cnt_reg == 2'd3) begin
                  MODO <= MODE_HOLD;
`ifdef CTRL_DESP_PARITY_EN
                  state_reg <= PAR;
`else
                  state_reg <= CAPT;
`endif
               end
            end
`ifdef CTRL_DESP_PARITY_EN
            PAR: begin
               TX_VALID    <= 1'b0;
               par_bit_reg <= SER_IN;
               state_reg   <= CAPT;
            end
`endif
            CAPT: begin
               TX_VALID  <= 1'b0;
               RX_WORD   <= Q_IN;
`ifdef CTRL_DESP_PARITY_EN
               // Even parity: data bits plus parity bit must XOR to 0.
               PAR_ERR   <= (^Q_IN) ^ par_bit_reg;
`endif
               DONE      <= 1'b1;
               BUSY      <= 1'b0;
               DIR       <= 1'b0;
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
               MODO      <= MODE_HOLD;
               BUSY      <= 1'b0;
               TX_VALID  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ctrl_desp.sv
// ---------------------------------------------------------------------------
// tb_ctrl_desp -- bench for ctrl_desp. Contains a model of the external 4-bit
// shift register (S_OUT registered) that closes the loop on Q_IN, a timeline
// model of the expected controller outputs, a per-cycle compare process and
// directed transfers with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_ctrl_desp;

`ifdef CTRL_DESP_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif
   // Timeline index of the CAPT cycle counted from the LOAD cycle (index 0).
   localparam int LAST_K = PAR_EN ? 6 : 5;
   // Edges from the accepting edge until DONE is visible, and repeat period.
   localparam int LAT    = PAR_EN ? 7 : 6;
   localparam int PERIOD = PAR_EN ? 8 : 7;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       START = 1'b0;
   logic [3:0] DIN = 4'd0;
   logic       DIR_CFG = 1'b0;
   logic       SER_IN = 1'b0;
   logic [3:0] Q_IN;
   logic       ENB, DIR, S_IN, BUSY, TX_VALID, DONE, PAR_ERR;
   logic [1:0] MODO;
   logic [3:0] D, RX_WORD;

   int tests = 0;
   int fails = 0;

   ctrl_desp dut (
      .CLK(CLK), .RST(RST), .START(START), .DIN(DIN), .DIR_CFG(DIR_CFG),
      .SER_IN(SER_IN), .Q_IN(Q_IN), .ENB(ENB), .DIR(DIR), .MODO(MODO),
      .D(D), .S_IN(S_IN), .BUSY(BUSY), .TX_VALID(TX_VALID),
      .RX_WORD(RX_WORD), .DONE(DONE), .PAR_ERR(PAR_ERR)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- external shift register -------------------------------
   logic [3:0] sr = 4'd0;
   logic       S_OUT = 1'b0;
   assign Q_IN = sr;
   always @(posedge CLK) begin
      if (ENB) begin
         case (MODO)
            2'b00: begin
               if (DIR) begin
                  sr    <= {S_IN, sr[3:1]};
                  S_OUT <= sr[0];
               end else begin
                  sr    <= {sr[2:0], S_IN};
                  S_OUT <= sr[3];
               end
            end
            2'b10:   sr <= D;
            default: ;
         endcase
      end
   end

   // ---------------- controller timeline model -----------------------------
   // k = -1 idle, 0 LOAD, 1..4 SHIFT, 5 PAR (parity build), LAST_K CAPT.
   int         k = -1;
   logic [3:0] din_l = 4'd0;
   logic       dir_l = 1'b0;
   logic [3:0] rb = 4'd0;          // rb[i] = i-th received bit
   logic       p_l = 1'b0;
   logic       done_e = 1'b0;
   logic [3:0] rx_e = 4'd0;
   logic       perr_e = 1'b0;
   logic [3:0] word_now;

   // MSB-first: first received bit ends at MSB; LSB-first: at LSB.
   assign word_now = dir_l ? {rb[3], rb[2], rb[1], rb[0]} : {rb[0], rb[1], rb[2], rb[3]};

   always @(posedge CLK or posedge RST) begin
      if (RST) begin
         k      <= -1;
         done_e <= 1'b0;
         rx_e   <= 4'd0;
         perr_e <= 1'b0;
      end else begin
         done_e <= 1'b0;
         if (k < 0) begin
            if (START) begin
               k     <= 0;
               din_l <= DIN;
               dir_l <= DIR_CFG;
            end
         end else if (k == LAST_K) begin
            rx_e   <= word_now;
            perr_e <= PAR_EN ? ((^word_now) ^ p_l) : 1'b0;
            done_e <= 1'b1;
            k      <= -1;
         end else begin
            if (k >= 1 && k <= 4) rb[2'(k - 1)] <= SER_IN;
            if (k == 5) p_l <= SER_IN;
            k <= k + 1;
         end
      end
   end

   // ---------------- per-cycle compare -------------------------------------
   always @(negedge CLK) begin
      automatic logic [1:0] e_modo = (k == 0) ? 2'b10 : (k >= 1 && k <= 4) ? 2'b00 : 2'b11;
      chk("ENB",      8'(ENB),      8'(1'b1));
      chk("MODO",     8'(MODO),     8'(e_modo));
      chk("D",        8'(D),        8'((k == 0) ? din_l : 4'd0));
      chk("BUSY",     8'(BUSY),     8'(k >= 0));
      chk("TX_VALID", 8'(TX_VALID), 8'(k >= 2 && k <= 5));
      chk("S_IN",     8'(S_IN),     8'((k >= 1 && k <= 4) ? SER_IN : 1'b0));
      chk("DONE",     8'(DONE),     8'(done_e));
      chk("RX_WORD",  8'(RX_WORD),  8'(rx_e));
      chk("PAR_ERR",  8'(PAR_ERR),  8'(perr_e));
      if (k >= 1 && k <= 4) chk("DIR", 8'(DIR), 8'(dir_l));
      if (k >= 2 && k <= 5)
         chk("S_OUT", 8'(S_OUT), 8'(dir_l ? din_l[2'(k - 2)] : din_l[2'(5 - k)]));
   end

   // ---------------- directed transfers ------------------------------------
   // ser / exp_tx: first bit in time at bit [3]. Call #1 after a rising edge.
   task automatic run_xfer(input logic [3:0] din, input logic dir, input logic [3:0] ser,
                           input logic p, input logic glitch, input logic [3:0] exp_tx,
                           input logic [3:0] exp_rx, input logic exp_perr);
      int lat = 0;
      int n_done = 0;
      int ntx = 0;
      logic [3:0] txv = 4'd0;
      START = 1'b1; DIN = din; DIR_CFG = dir; SER_IN = 1'b0;
      @(posedge CLK); #1;
      START = 1'b0; DIN = ~din; DIR_CFG = ~dir;   // must not affect this transfer
      for (int n = 1; n <= 20; n++) begin
         @(posedge CLK); #1;
         if (n <= 4)       SER_IN = ser[4 - n];
         else if (n == 5)  SER_IN = p;
         else              SER_IN = 1'($urandom_range(0, 1));
         START = glitch && (n == 2);
         @(negedge CLK);
         if (TX_VALID) begin
            if (ntx < 4) txv[2'(3 - ntx)] = S_OUT;
            ntx++;
         end
         if (DONE) begin
            n_done++;
            if (lat == 0) lat = n;
         end
      end
      @(posedge CLK); #1;
      START = 1'b0;
      chk("latency",   8'(lat),     8'(LAT));
      chk("done_cnt",  8'(n_done),  8'd1);
      chk("tx_count",  8'(ntx),     8'd4);
      chk("tx_bits",   8'(txv),     8'(exp_tx));
      chk("rx_word",   8'(RX_WORD), 8'(exp_rx));
      chk("par_err",   8'(PAR_ERR), 8'(exp_perr));
      $display("[TB] xfer din=%b dir=%b ser=%b p=%b -> tx=%b rx=%b perr=%b lat=%0d",
               din, dir, ser, p, txv, RX_WORD, PAR_ERR, lat);
   endtask

   initial begin
      int dones[$];
      int extra;
      // Reset, then 10 idle cycles
      RST = 1'b1;
      repeat (3) @(posedge CLK);
      #1 RST = 1'b0;
      repeat (10) @(posedge CLK);
      #1;
      chk("idle_MODO", 8'(MODO), 8'h3);
      chk("idle_ENB",  8'(ENB),  8'h1);
      chk("idle_BUSY", 8'(BUSY), 8'h0);
      chk("idle_DONE", 8'(DONE), 8'h0);
      chk("idle_RX",   8'(RX_WORD), 8'h0);
      $display("[TB] reset idle MODO=%b BUSY=%b RX=%b", MODO, BUSY, RX_WORD);

      // MSB first, received 0,1,1,0
      run_xfer(4'b1010, 1'b0, 4'b0110, 1'b0, 1'b0, 4'b1010, 4'b0110, 1'b0);
      // LSB first, SER_IN stuck at 1, extra START pulse during SHIFT
      run_xfer(4'b0001, 1'b1, 4'b1111, 1'b0, 1'b1, 4'b1000, 4'b1111, 1'b0);
      // Parity: RX 0,1,1,0 with P=1 then P=0
      run_xfer(4'b0011, 1'b0, 4'b0110, 1'b1, 1'b0, 4'b0011, 4'b0110, PAR_EN);
      run_xfer(4'b0011, 1'b0, 4'b0110, 1'b0, 1'b0, 4'b0011, 4'b0110, 1'b0);

      // START held high: back-to-back transfers
      START = 1'b1; DIN = 4'b1100; DIR_CFG = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         @(posedge CLK); #1;
         SER_IN = 1'($urandom_range(0, 1));
         @(negedge CLK);
         if (DONE) dones.push_back(n);
      end
      @(posedge CLK); #1 START = 1'b0;
      chk("held_ndone", 8'(dones.size() >= 3), 8'h1);
      if (dones.size() >= 3) begin
         chk("held_first", 8'(dones[0]), 8'(LAT + 1));
         chk("held_gap1",  8'(dones[1] - dones[0]), 8'(PERIOD));
         chk("held_gap2",  8'(dones[2] - dones[1]), 8'(PERIOD));
         $display("[TB] held START dones at %0d %0d %0d", dones[0], dones[1], dones[2]);
      end
      repeat (12) @(posedge CLK);
      #1;

      // Reset asserted during SHIFT with CNT=2
      START = 1'b1; DIN = 4'b1010; DIR_CFG = 1'b0;
      @(posedge CLK); #1 START = 1'b0;
      repeat (3) @(posedge CLK);
      #1 RST = 1'b1;
      #1;
      chk("rst_MODO", 8'(MODO), 8'h3);
      chk("rst_BUSY", 8'(BUSY), 8'h0);
      chk("rst_D",    8'(D),    8'h0);
      chk("rst_TXV",  8'(TX_VALID), 8'h0);
      chk("rst_ENB",  8'(ENB),  8'h1);
      $display("[TB] reset mid-transfer MODO=%b BUSY=%b", MODO, BUSY);
      @(posedge CLK); #1 RST = 1'b0;
      extra = 0;
      for (int n = 0; n < 10; n++) begin
         @(negedge CLK);
         if (DONE) extra++;
      end
      chk("rst_nodone", 8'(extra), 8'h0);
      @(posedge CLK); #1;
      run_xfer(4'b1010, 1'b0, 4'b0110, 1'b0, 1'b0, 4'b1010, 4'b0110, 1'b0);

      repeat (3) @(posedge CLK);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ctrl_desp.md
CTRL_DESP -- requirements
Module: ctrl_desp

Interface
REQ-001 The block SHALL have port CLK, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have port START, input, 1 bit: transfer request, sampled in IDLE only.
REQ-004 The block SHALL have port DIN, input, 4 bits: word to transmit, latched when START is accepted.
REQ-005 The block SHALL have port DIR_CFG, input, 1 bit: shift direction, latched when START is accepted (0 = left/MSB first, 1 = right/LSB first).
REQ-006 The block SHALL have port SER_IN, input, 1 bit: serial receive line.
REQ-007 The block SHALL have port Q_IN, input, 4 bits: shift register parallel contents.
REQ-008 The block SHALL have port ENB, output, 1 bit: shift register mode-load enable.
REQ-009 The block SHALL have port DIR, output, 1 bit: shift register direction.
REQ-010 The block SHALL have port MODO, output, 2 bits: shift register mode (00 shift, 10 parallel load, 11 hold).
REQ-011 The block SHALL have port D, output, 4 bits: shift register parallel data.
REQ-012 The block SHALL have port S_IN, output, 1 bit: shift register serial input.
REQ-013 The block SHALL have port BUSY, output, 1 bit: high in every non-IDLE state.
REQ-014 The block SHALL have port TX_VALID, output, 1 bit: shift register S_OUT carries a valid transmitted bit this cycle.
REQ-015 The block SHALL have port RX_WORD, output, 4 bits: last received word (registered).
REQ-016 The block SHALL have port DONE, output, 1 bit: one-cycle completion pulse.
REQ-017 The block SHALL have port PAR_ERR, output, 1 bit: parity error of the last transfer, valid with DONE.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD, SHIFT, [PAR], CAPT and SHALL use a 2-bit shift counter CNT.
REQ-019 ENB SHALL be 1 in all states, including during reset.
REQ-020 MODO SHALL be 11 in IDLE/PAR/CAPT, 10 in LOAD and 00 in SHIFT, so the shift register never free-runs when idle.
REQ-021 IDLE→LOAD SHALL occur when START=1 at a rising edge, latching DIN and DIR_CFG at that edge.
REQ-022 In LOAD, D SHALL equal the latched DIN; the next state SHALL be SHIFT with CNT=0; D SHALL be 0 in all other states.
REQ-023 In SHIFT, DIR SHALL equal the latched direction and S_IN SHALL equal SER_IN (combinational); S_IN SHALL be 0 outside SHIFT.
REQ-024 CNT SHALL increment each SHIFT cycle; SHIFT SHALL exit after exactly 4 cycles (CNT=3), to PAR if compiled in, otherwise to CAPT.
REQ-025 TX_VALID SHALL be 1 in SHIFT cycles with CNT=1..3 and in the first cycle after SHIFT exits, otherwise 0.
REQ-026 In CAPT, RX_WORD SHALL load Q_IN at the edge ending CAPT; DONE SHALL be 1 for the following single cycle (IDLE); the next state SHALL be IDLE.
REQ-027 Latency: with PAR excluded, for START sampled at edge t0, DONE SHALL be high in cycle t0+7 (t0+8 with PAR).
REQ-028 START while BUSY SHALL be ignored and SHALL NOT be queued.
REQ-029 START held high continuously SHALL begin a new transfer in the IDLE cycle in which DONE=1, giving back-to-back transfers.
REQ-030 DIN/DIR_CFG changes while BUSY SHALL have no effect on the current transfer.

Reset
REQ-031 On RST high, the block SHALL asynchronously set: state=IDLE, CNT=0, ENB=1, MODO=11, DIR=0, D=0, S_IN=0, BUSY=0, TX_VALID=0, RX_WORD=0, DONE=0, PAR_ERR=0.
REQ-032 RST mid-transfer SHALL abort the transfer with no DONE pulse; the first START after release SHALL be accepted normally.

Configuration
REQ-033 The macro CTRL_DESP_PARITY_EN SHALL control the parity feature.
REQ-034 With CTRL_DESP_PARITY_EN defined: a one-cycle PAR state SHALL follow SHIFT (MODO=11); SER_IN SHALL be sampled as the parity bit P; PAR_ERR SHALL be set at the edge ending CAPT to XOR(RX_WORD bits, P) (even parity) and SHALL hold until the next DONE.
REQ-035 With CTRL_DESP_PARITY_EN undefined: there SHALL be no PAR state, and PAR_ERR SHALL be a constant 0.

Verification
REQ-036 Reset then idle 10 cycles → MODO=11, ENB=1, BUSY=0, DONE=0, RX_WORD=0000.
REQ-037 DIN=1010, DIR_CFG=0, SER_IN bits 0,1,1,0 in SHIFT cycles → MODO sequence 10,00,00,00,00,11; S_OUT bits 1,0,1,0 while TX_VALID=1; RX_WORD=0110; DONE at t0+7.
REQ-038 DIN=0001, DIR_CFG=1, SER_IN=1 constant → S_OUT 1,0,0,0 (LSB first); RX_WORD=1111.
REQ-039 START pulsed again during SHIFT → ignored, exactly one DONE pulse; START held high → DONE every 7 cycles (8 with parity).
REQ-040 RST asserted at CNT=2 → immediate IDLE, MODO=11, no DONE; the next transfer completes correctly.
REQ-041 Parity build: RX bits 0,1,1,0 with P=1 → PAR_ERR=1; with P=0 → PAR_ERR=0; DONE at t0+8.
